imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified memory between instruction fetch (I port) and the MEM-stage load/store unit (D port) of the pipelined RV32I core.
- Data requests have priority. A streak counter bounds instruction starvation.
- Each requester holds its request level-high until it sees a one-cycle ready pulse. The hazard logic uses i_busy/d_busy to stall the pipeline.

---
 rtl/imem_dmem_arbiter_pkg.sv | 27 ++
 rtl/imem_dmem_arbiter_arb_grant.sv | 33 +++
 rtl/imem_dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter_pkg
//   Shared definitions for the unified-memory arbiter: FSM state encoding,
//   streak counter width/saturation value, default starvation bound and a
//   saturating increment helper.
// -----------------------------------------------------------------------------
package imem_dmem_arbiter_pkg;

  // Arbiter FSM states. Encoding is fixed so waveforms match the core docs.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Consecutive-D-grant counter: 4 bits covers the legal MAX_D_STREAK 1..15.
  localparam int              STREAK_W             = 4;
  localparam logic [STREAK_W-1:0] STREAK_SAT       = '1;
  localparam int              DEFAULT_MAX_D_STREAK = 4;

  // Saturating increment for the streak counter.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == STREAK_SAT) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_arb_grant.sv
// -----------------------------------------------------------------------------
// arb_grant
//   Combinational grant selection for the I/D arbiter. Data wins unless an
//   instruction fetch is waiting and data has already taken MAX_D_STREAK
//   consecutive grants.
//
// Ports
//   i_req   in   instruction fetch request
//   d_req   in   data request
//   streak  in   consecutive D grants taken while an I request was pending
//   gnt_i   out  grant to the I port (one-hot with gnt_d, or both zero)
//   gnt_d   out  grant to the D port
// -----------------------------------------------------------------------------
module arb_grant
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                gnt_i,
  output logic                gnt_d
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  always_comb begin
    gnt_d = d_req & (~i_req | (streak < MAX_STREAK));
    gnt_i = i_req & ~gnt_d;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter
//   Shares one single-port unified memory between instruction fetch (I port)
//   and the load/store unit (D port). Data has priority; a streak counter
//   bounds instruction starvation. Each access runs IDLE -> *_BUSY -> RESP,
//   so a zero-wait memory gives one access every 3 cycles.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   i_req/i_addr               fetch request and address (held until i_ready)
//   i_rdata/i_ready/i_busy     fetched word, 1-cycle done pulse, stall
//   d_req/d_we/d_addr/
//   d_wdata/d_be               load/store request (held until d_ready)
//   d_rdata/d_ready/d_busy     load data (0 for stores), done pulse, stall
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be           memory request, held until mem_ack
//   mem_rdata/mem_ack          memory read data and 1-cycle completion
// -----------------------------------------------------------------------------
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
  input  logic            clk,
  input  logic            reset,
  // instruction port
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  output logic            i_busy,
  // data port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            d_busy,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  localparam int BW = DW / 8;

  arb_state_t          state, state_n;
  logic [STREAK_W-1:0] streak, streak_n;

  logic            mem_req_n, mem_we_n;
  logic [AW-1:0]   mem_addr_n;
  logic [DW-1:0]   mem_wdata_n;
  logic [BW-1:0]   mem_be_n;
  logic            i_ready_n, d_ready_n;
  logic [DW-1:0]   i_rdata_n, d_rdata_n;

  logic gnt_i, gnt_d;

  arb_grant #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_grant (
    .i_req  (i_req),
    .d_req  (d_req),
    .streak (streak),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  // Stall signals are the only combinational outputs.
  assign i_busy = i_req & ~i_ready;
  assign d_busy = d_req & ~d_ready;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_n     = state;
    streak_n    = streak;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_be_n    = mem_be;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    i_ready_n   = 1'b0;
    d_ready_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (gnt_d) begin
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          mem_be_n    = d_be;
          // Only D grants taken while a fetch waits count towards starvation.
          streak_n    = i_req ? streak_inc(streak) : '0;
          state_n     = D_BUSY;
        end else if (gnt_i) begin
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = i_addr;
          mem_wdata_n = '0;
          mem_be_n    = '1;
          streak_n    = '0;
          state_n     = I_BUSY;
        end
      end

      I_BUSY: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          i_rdata_n = mem_rdata;
          i_ready_n = 1'b1;
          state_n   = RESP;
        end
      end

      D_BUSY: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          d_rdata_n = mem_we ? '0 : mem_rdata;
          d_ready_n = 1'b1;
          state_n   = RESP;
        end
      end

      // The ready pulse is already on the registered outputs in this state;
      // the requester drops or replaces its request before we return to IDLE.
      RESP: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the read-data holding registers are reset along with control
      // because they are ports whose reset value is defined as 0.
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= state_n;
      streak    <= streak_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_be    <= mem_be_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      i_ready   <= i_ready_n;
      d_ready   <= d_ready_n;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_dmem_arbiter
//   Self-checking bench: the bench plays both requesters and the memory,
//   keeps a word-addressed memory model and predicts grant winners from the
//   starvation rule, then checks every memory-side and port-side output.
// -----------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready, i_busy;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_ready, d_busy;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .AW (AW), .DW (DW), .MAX_D_STREAK (MAXS)
  ) dut (
    .clk (clk), .reset (reset),
    .i_req (i_req), .i_addr (i_addr), .i_rdata (i_rdata),
    .i_ready (i_ready), .i_busy (i_busy),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_be (d_be), .d_rdata (d_rdata), .d_ready (d_ready), .d_busy (d_busy),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_be (mem_be),
    .mem_rdata (mem_rdata), .mem_ack (mem_ack)
  );

  int tests = 0;
  int fails = 0;

  // Reference state
  int            streak_m;
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] last_i, last_d;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic wr_model(input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input logic [BW-1:0] be);
    logic [DW-1:0] word;
    word = rd_model(a);
    for (int b = 0; b < BW; b++)
      if (be[b]) word[8*b +: 8] = w[8*b +: 8];
    mem_model[a] = word;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("i_busy", 32'(i_busy), 32'(i_req & ~i_ready));
    check("d_busy", 32'(d_busy), 32'(d_req & ~d_ready));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),   '0);
    check({tag, "_mem_we"},    32'(mem_we),    '0);
    check({tag, "_mem_addr"},  mem_addr,       '0);
    check({tag, "_mem_wdata"}, mem_wdata,      '0);
    check({tag, "_mem_be"},    32'(mem_be),    '0);
    check({tag, "_i_ready"},   32'(i_ready),   '0);
    check({tag, "_d_ready"},   32'(d_ready),   '0);
    check({tag, "_i_rdata"},   i_rdata,        '0);
    check({tag, "_d_rdata"},   d_rdata,        '0);
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = 32'($urandom_range(0, 31)) << 2;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = 32'($urandom_range(0, 31)) << 2;
    d_wdata = $urandom;
    d_be    = 4'($urandom_range(1, 15));
  endtask

  // One cycle with nothing requested; optional stray ack must be ignored.
  task automatic idle_cycle(input bit ack);
    mem_ack   = ack;
    mem_rdata = $urandom;
    tick();
    check("idle_mem_req", 32'(mem_req), '0);
    check("idle_i_ready", 32'(i_ready), '0);
    check("idle_d_ready", 32'(d_ready), '0);
    check("idle_i_rdata", i_rdata, last_i);
    check("idle_d_rdata", d_rdata, last_d);
    mem_ack = 1'b0;
  endtask

  // One complete access starting from IDLE with at least one request held.
  // won_d returns the port the DUT actually pulsed ready on.
  task automatic do_access(input int waits, input bit resp_ack,
                           input bit renew_i, input bit renew_d,
                           output bit won_d);
    bit            exp_d, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, rd;
    logic [BW-1:0] exp_be;

    exp_d = d_req && (!i_req || streak_m < MAXS);
    if (exp_d) begin
      exp_we    = d_we;
      exp_addr  = d_addr;
      exp_wdata = d_wdata;
      exp_be    = d_be;
      streak_m  = i_req ? ((streak_m < 15) ? streak_m + 1 : 15) : 0;
    end else begin
      exp_we    = 1'b0;
      exp_addr  = i_addr;
      exp_wdata = '0;
      exp_be    = '1;
      streak_m  = 0;
    end

    // Grant edge: request goes out to memory.
    tick();
    check("g_mem_req",  32'(mem_req), 1);
    check("g_mem_we",   32'(mem_we),  32'(exp_we));
    check("g_mem_addr", mem_addr,     exp_addr);
    check("g_mem_be",   32'(mem_be),  32'(exp_be));
    if (exp_d) check("g_mem_wdata", mem_wdata, exp_wdata);
    check("g_i_ready",  32'(i_ready), '0);
    check("g_d_ready",  32'(d_ready), '0);

    for (int w = 0; w < waits; w++) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      tick();
      check("w_mem_req",  32'(mem_req), 1);
      check("w_mem_addr", mem_addr,     exp_addr);
      check("w_mem_we",   32'(mem_we),  32'(exp_we));
      check("w_mem_be",   32'(mem_be),  32'(exp_be));
      check("w_i_ready",  32'(i_ready), '0);
      check("w_d_ready",  32'(d_ready), '0);
    end

    // Memory acknowledges.
    mem_ack = 1'b1;
    if (exp_d && exp_we) begin
      wr_model(exp_addr, exp_wdata, exp_be);
      mem_rdata = $urandom;
      rd        = '0;
    end else begin
      rd        = rd_model(exp_addr);
      mem_rdata = rd;
    end
    if (exp_d) last_d = rd; else last_i = rd;

    tick();
    won_d = d_ready;
    check("r_mem_req", 32'(mem_req), '0);
    check("r_i_ready", 32'(i_ready), 32'(!exp_d));
    check("r_d_ready", 32'(d_ready), 32'(exp_d));
    check("r_i_rdata", i_rdata, last_i);
    check("r_d_rdata", d_rdata, last_d);

    // Requester reacts to ready; a stray ack during the response is ignored.
    mem_ack   = resp_ack;
    mem_rdata = $urandom;
    if (exp_d) begin
      d_req = 1'b0;
      if (renew_d) new_d();
    end else begin
      i_req = 1'b0;
      if (renew_i) new_i();
    end

    tick();
    check("e_mem_req", 32'(mem_req), '0);
    check("e_i_ready", 32'(i_ready), '0);
    check("e_d_ready", 32'(d_ready), '0);
    check("e_i_rdata", i_rdata, last_i);
    check("e_d_rdata", d_rdata, last_d);
    mem_ack = 1'b0;
  endtask

  initial begin
    bit won;
    bit exp_order [6];

    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    streak_m = 0; last_i = '0; last_d = '0;

    // Reset state
    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b1;

    // Single I fetch, zero-wait memory
    mem_model[32'h100] = 32'h0050_0093;
    i_req  = 1'b1;
    i_addr = 32'h100;
    do_access(0, 0, 0, 0, won);
    check("t1_i_rdata", i_rdata, 32'h0050_0093);

    // D store with two wait states
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    do_access(2, 0, 0, 0, won);
    check("t2_won_d", 32'(won), 1);

    // Starvation bound: I held, D continuously renewed
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    i_req = 1'b1; i_addr = 32'h40;
    new_d();
    for (int k = 0; k < 6; k++) begin
      do_access(0, 0, 0, (k < 5), won);
      check($sformatf("t3_order_%0d", k), 32'(won), 32'(exp_order[k]));
    end

    // Back-to-back loads, no fetch pending
    for (int k = 0; k < 4; k++) begin
      new_d();
      d_we = 1'b0;
      do_access(0, 0, 0, 0, won);
      check("t4_won_d", 32'(won), 1);
    end

    // Reset during D_BUSY before ack; late ack must be ignored
    new_d();
    d_we = 1'b0;
    tick();
    check("t5_mem_req", 32'(mem_req), 1);
    tick();
    reset = 1'b0; d_req = 1'b0;
    tick();
    check_all_zero("t5");
    reset = 1'b1; mem_ack = 1'b1;
    streak_m = 0; last_i = '0; last_d = '0;
    tick();
    check("t5_late_mem_req", 32'(mem_req), '0);
    check("t5_late_d_ready", 32'(d_ready), '0);
    check("t5_late_i_ready", 32'(i_ready), '0);
    mem_ack = 1'b0;
    tick();
    check("t5_after_d_ready", 32'(d_ready), '0);

    // Spurious acks while IDLE
    idle_cycle(1);
    idle_cycle(1);
    idle_cycle(0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!i_req && !d_req) begin
        idle_cycle(1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) != 0) new_i();
        if ($urandom_range(0, 1) != 0) new_d();
        if (!i_req && !d_req) new_d();
      end
      do_access($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), won);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
